// File: rtl/convolution_engine_if.sv
// Bundles the control and memory-side signals of the convolution engine.
// The engine takes the slave modport. The master side owns start/config
// and also models the sample memories.
interface convolution_engine_if #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned DATA_WIDTH_OUT    = 16,
  parameter int unsigned ADDRESS_WIDTH     = 5,
  parameter int unsigned ADDRESS_WIDTH_OUT = ADDRESS_WIDTH + 1
);
  logic                         start_i;
  logic [ADDRESS_WIDTH-1:0]     size_y_i;
  logic [ADDRESS_WIDTH-1:0]     size_h_i;
  logic                         signed_i;
  logic [DATA_WIDTH-1:0]        data_y_i;
  logic [DATA_WIDTH-1:0]        data_h_i;
  logic [ADDRESS_WIDTH-1:0]     mem_y_addr_o;
  logic [ADDRESS_WIDTH-1:0]     mem_h_addr_o;
  logic [DATA_WIDTH_OUT-1:0]    data_z_o;
  logic [ADDRESS_WIDTH_OUT-1:0] mem_z_addr_o;
  logic                         write_o;
  logic                         busy_o;
  logic                         done_o;
  logic                         sat_o;

  modport master (
    output start_i, size_y_i, size_h_i, signed_i, data_y_i, data_h_i,
    input  mem_y_addr_o, mem_h_addr_o, data_z_o, mem_z_addr_o, write_o, busy_o, done_o, sat_o
  );

  modport slave (
    input  start_i, size_y_i, size_h_i, signed_i, data_y_i, data_h_i,
    output mem_y_addr_o, mem_h_addr_o, data_z_o, mem_z_addr_o, write_o, busy_o, done_o, sat_o
  );
endinterface

// File: rtl/convolution_engine.sv
// Output-stationary convolution engine: z[i] = sum h[j]*y[i-j], one MAC per
// valid tap, wide accumulator, saturating result written to Z memory.
module convolution_engine #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned DATA_WIDTH_OUT    = 16,
  parameter int unsigned ADDRESS_WIDTH     = 5,
  parameter int unsigned ADDRESS_WIDTH_OUT = ADDRESS_WIDTH + 1
) (
  input logic                 clk,
  input logic                 rst,
  convolution_engine_if.slave bus
);
  localparam int unsigned AccWidth  = 2 * DATA_WIDTH + ADDRESS_WIDTH;
  localparam int unsigned ProdWidth = 2 * DATA_WIDTH + 1;
  localparam int unsigned IdxWidth  = ADDRESS_WIDTH_OUT + 1;

  typedef enum logic [2:0] {
    StIdle, StSetup, StFetch, StMac, StDrain, StWrite, StDone
  } state_e;

  state_e                       state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]     size_y_q, size_y_d, size_h_q, size_h_d;
  logic                         signed_q, signed_d;
  logic [ADDRESS_WIDTH_OUT-1:0] sz_q, sz_d, i_q, i_d;
  logic [ADDRESS_WIDTH-1:0]     j_q, j_d, jmax_q, jmax_d;
  logic [AccWidth-1:0]          acc_q, acc_d;
  logic                         acc_en_q, acc_en_d;
  logic [ADDRESS_WIDTH-1:0]     addr_y_q, addr_y_d, addr_h_q, addr_h_d;
  logic [ADDRESS_WIDTH_OUT-1:0] addr_z_q, addr_z_d;
  logic [DATA_WIDTH_OUT-1:0]    data_z_q, data_z_d;
  logic                         write_q, write_d, busy_q, busy_d, done_q, done_d, sat_q, sat_d;

  logic [ADDRESS_WIDTH-1:0]     jmin_c, jmax_c;
  logic [ADDRESS_WIDTH_OUT-1:0] sz_c;
  logic [IdxWidth-1:0]          i_plus1;
  logic signed [ProdWidth-1:0]  h_ext, y_ext, prod;
  logic [AccWidth-1:0]          acc_fin;
  logic [DATA_WIDTH_OUT-1:0]    sat_val;
  logic                         clamp;
  logic [AccWidth-DATA_WIDTH_OUT:0] upper;

  // Tap window for the current output index and the run length.
  always_comb begin
    i_plus1 = IdxWidth'(i_q) + IdxWidth'(1);
    jmin_c  = (i_plus1 > IdxWidth'(size_y_q)) ? ADDRESS_WIDTH'(i_plus1 - IdxWidth'(size_y_q)) : '0;
    jmax_c  = (i_q < ADDRESS_WIDTH_OUT'(size_h_q)) ? ADDRESS_WIDTH'(i_q) : size_h_q - 1'b1;
    sz_c    = (size_y_q == '0 || size_h_q == '0) ? '0 :
              ADDRESS_WIDTH_OUT'(size_y_q) + ADDRESS_WIDTH_OUT'(size_h_q) - 1'b1;
  end

  // Product of last cycle's memory data, extended per mode; saturate final sum.
  always_comb begin
    h_ext   = ProdWidth'({{(ProdWidth - DATA_WIDTH){signed_q & bus.data_h_i[DATA_WIDTH-1]}},
                          bus.data_h_i});
    y_ext   = ProdWidth'({{(ProdWidth - DATA_WIDTH){signed_q & bus.data_y_i[DATA_WIDTH-1]}},
                          bus.data_y_i});
    prod    = h_ext * y_ext;
    acc_fin = acc_en_q ? acc_q + {{(AccWidth - ProdWidth){prod[ProdWidth-1]}}, prod} : acc_q;
    upper   = acc_fin[AccWidth-1:DATA_WIDTH_OUT-1];
    sat_val = acc_fin[DATA_WIDTH_OUT-1:0];
    clamp   = 1'b0;
    if (signed_q) begin
      if (!((&upper) || !(|upper))) begin
        clamp   = 1'b1;
        sat_val = acc_fin[AccWidth-1] ? {1'b1, {(DATA_WIDTH_OUT - 1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH_OUT - 1){1'b1}}};
      end
    end else if (|acc_fin[AccWidth-1:DATA_WIDTH_OUT]) begin
      clamp   = 1'b1;
      sat_val = '1;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    size_y_d = size_y_q;
    size_h_d = size_h_q;
    signed_d = signed_q;
    sz_d     = sz_q;
    i_d      = i_q;
    j_d      = j_q;
    jmax_d   = jmax_q;
    acc_d    = acc_fin;
    addr_y_d = addr_y_q;
    addr_h_d = addr_h_q;
    addr_z_d = addr_z_q;
    data_z_d = data_z_q;
    write_d  = 1'b0;
    sat_d    = sat_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d  = StSetup;
          size_y_d = bus.size_y_i;
          size_h_d = bus.size_h_i;
          signed_d = bus.signed_i;
          sat_d    = 1'b0;
        end
      end
      StSetup: begin
        sz_d    = sz_c;
        i_d     = '0;
        state_d = (sz_c == '0) ? StDone : StFetch;
      end
      StFetch: begin
        j_d      = jmin_c;
        jmax_d   = jmax_c;
        addr_h_d = jmin_c;
        addr_y_d = ADDRESS_WIDTH'(i_q - ADDRESS_WIDTH_OUT'(jmin_c));
        acc_d    = '0;
        state_d  = StMac;
      end
      StMac: begin
        if (j_q == jmax_q) begin
          state_d = StDrain;
        end else begin
          j_d      = j_q + 1'b1;
          addr_h_d = j_q + 1'b1;
          addr_y_d = ADDRESS_WIDTH'(i_q - ADDRESS_WIDTH_OUT'(j_q) - 1'b1);
        end
      end
      StDrain: begin
        // Result registered on this edge so it is presented during WRITE.
        state_d  = StWrite;
        write_d  = 1'b1;
        addr_z_d = i_q;
        data_z_d = sat_val;
        sat_d    = sat_q | clamp;
      end
      StWrite: begin
        if (ADDRESS_WIDTH_OUT'(i_q + 1'b1) < sz_q) begin
          i_d     = i_q + 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    acc_en_d = (state_q == StMac);
    busy_d   = (state_d != StIdle) && (state_d != StDone);
    done_d   = (state_q == StDone);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      size_y_q <= '0;
      size_h_q <= '0;
      signed_q <= 1'b0;
      sz_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      jmax_q   <= '0;
      acc_q    <= '0;
      acc_en_q <= 1'b0;
      addr_y_q <= '0;
      addr_h_q <= '0;
      addr_z_q <= '0;
      data_z_q <= '0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_y_q <= size_y_d;
      size_h_q <= size_h_d;
      signed_q <= signed_d;
      sz_q     <= sz_d;
      i_q      <= i_d;
      j_q      <= j_d;
      jmax_q   <= jmax_d;
      acc_q    <= acc_d;
      acc_en_q <= acc_en_d;
      addr_y_q <= addr_y_d;
      addr_h_q <= addr_h_d;
      addr_z_q <= addr_z_d;
      data_z_q <= data_z_d;
      write_q  <= write_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sat_q    <= sat_d;
    end
  end

  assign bus.mem_y_addr_o = addr_y_q;
  assign bus.mem_h_addr_o = addr_h_q;
  assign bus.mem_z_addr_o = addr_z_q;
  assign bus.data_z_o     = data_z_q;
  assign bus.write_o      = write_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.sat_o        = sat_q;
endmodule

// File: tb/tb_convolution_engine.sv
// Directed bench for convolution_engine with synchronous Y/H memory models.
module tb_convolution_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  convolution_engine_if bus ();
  convolution_engine u_dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem_y [32];
  logic [7:0] mem_h [32];
  always @(posedge clk) begin
    bus.data_y_i <= mem_y[bus.mem_y_addr_o];
    bus.data_h_i <= mem_h[bus.mem_h_addr_o];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int wr_addr[$];
  int wr_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor write strobes and done pulses away from the active edge.
  always @(negedge clk) begin
    if (bus.write_o) begin
      wr_addr.push_back(int'(bus.mem_z_addr_o));
      wr_data.push_back(int'(bus.data_z_o));
    end
    if (bus.done_o) done_cnt++;
    if (bus.busy_o && bus.done_o) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int sy, input int sh, input logic [7:0] yv, input logic [7:0] hv);
    for (int k = 0; k < 32; k++) begin
      mem_y[k] = (k < sy) ? yv : 8'h00;
      mem_h[k] = (k < sh) ? hv : 8'h00;
    end
  endtask

  // Starts a run, waits (bounded) for done_o, checks latency and write count.
  task automatic do_run(input int sy, input int sh, input bit sgn, input int exp_n,
                        input string tag);
    int t0;
    bit seen;
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    bus.size_y_i = sy[4:0];
    bus.size_h_i = sh[4:0];
    bus.signed_i = sgn;
    bus.start_i  = 1'b1;
    @(posedge clk);
    t0 = cyc + 1;
    #1 bus.start_i = 1'b0;
    t0 = cyc;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    check({tag, "_done_cycle"}, seen ? cyc - t0 : -1, exp_n);
    check({tag, "_writes"}, wr_addr.size(), (sy == 0 || sh == 0) ? 0 : sy + sh - 1);
  endtask

  task automatic check_z(input string tag, input int idx, input int exp);
    check({tag, "_addr"}, (idx < wr_addr.size()) ? wr_addr[idx] : -1, idx);
    check({tag, "_data"}, (idx < wr_data.size()) ? wr_data[idx] : -1, exp);
  endtask

  int exp1[4] = '{1, 3, 5, 3};
  int exp2[3] = '{'hFFFD, 'h000A, 'hFFF8};
  int dc0, wc0;

  initial begin
    bus.start_i  = 1'b0;
    bus.size_y_i = '0;
    bus.size_h_i = '0;
    bus.signed_i = 1'b0;
    fill(0, 0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_outputs", {bus.mem_y_addr_o, bus.mem_h_addr_o, bus.mem_z_addr_o, bus.data_z_o,
                          bus.write_o, bus.busy_o, bus.done_o, bus.sat_o}, 0);
    rst = 1'b0;

    // Unsigned H=[1,2,3], Y=[1,1].
    fill(2, 3, 8'd1, 8'd0);
    mem_h[0] = 8'd1; mem_h[1] = 8'd2; mem_h[2] = 8'd3;
    do_run(2, 3, 1'b0, 20, "u3x2");
    for (int k = 0; k < 4; k++) check_z("u3x2_z", k, exp1[k]);
    check("u3x2_sat", bus.sat_o, 0);

    // Signed H=[-1,2], Y=[3,-4].
    fill(2, 2, 8'h00, 8'h00);
    mem_h[0] = 8'hFF; mem_h[1] = 8'h02; mem_y[0] = 8'h03; mem_y[1] = 8'hFC;
    do_run(2, 2, 1'b1, 15, "s2x2");
    for (int k = 0; k < 3; k++) check_z("s2x2_z", k, exp2[k]);

    // Saturation: 31x31 of 255 unsigned, 65025 per tap.
    fill(31, 31, 8'hFF, 8'hFF);
    do_run(31, 31, 1'b0, 961 + 183 + 2, "usat");
    check_z("usat_z0", 0, 'hFE01);
    check_z("usat_z1", 1, 'hFFFF);
    check_z("usat_z30", 30, 'hFFFF);
    check("usat_sat", bus.sat_o, 1);

    // Signed rerun with 0x80: z[0] = 16384, z[1] = 32768 clamps.
    fill(31, 31, 8'h80, 8'h80);
    fork
      do_run(31, 31, 1'b1, 961 + 183 + 2, "ssat");
      begin
        repeat (3) @(negedge clk);
        check("ssat_sat_cleared", bus.sat_o, 0);
        check("ssat_busy", bus.busy_o, 1);
      end
    join
    check_z("ssat_z0", 0, 'h4000);
    check_z("ssat_z1", 1, 'h7FFF);
    check_z("ssat_z30", 30, 'h7FFF);
    check("ssat_sat", bus.sat_o, 1);

    // Zero size and 1x1.
    do_run(3, 0, 1'b0, 2, "zero");
    fill(1, 1, 8'd9, 8'd7);
    do_run(1, 1, 1'b0, 6, "one");
    check_z("one_z", 0, 63);

    // start_i pulsed during MAC must be ignored.
    fill(2, 3, 8'd1, 8'd0);
    mem_h[0] = 8'd1; mem_h[1] = 8'd2; mem_h[2] = 8'd3;
    fork
      do_run(2, 3, 1'b0, 20, "ign");
      begin
        repeat (5) @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
      end
    join
    for (int k = 0; k < 4; k++) check_z("ign_z", k, exp1[k]);

    // Reset in MAC aborts at once; no further writes or done.
    @(negedge clk);
    bus.size_y_i = 5'd2; bus.size_h_i = 5'd3; bus.signed_i = 1'b0; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", bus.busy_o, 1);
    dc0 = done_cnt;
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {bus.mem_y_addr_o, bus.mem_h_addr_o, bus.mem_z_addr_o,
                              bus.data_z_o, bus.write_o, bus.busy_o, bus.done_o, bus.sat_o}, 0);
    wc0 = wr_addr.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_done", done_cnt - dc0, 0);
    check("rst_no_write", wr_addr.size() - wc0, 0);

    // Fresh run, then back-to-back start in the cycle after done_o.
    fill(2, 2, 8'h00, 8'h00);
    mem_h[0] = 8'hFF; mem_h[1] = 8'h02; mem_y[0] = 8'h03; mem_y[1] = 8'hFC;
    do_run(2, 2, 1'b1, 15, "fresh");
    for (int k = 0; k < 3; k++) check_z("fresh_z", k, exp2[k]);
    @(posedge clk);
    do_run(2, 2, 1'b1, 15, "b2b");
    check_z("b2b_z2", 2, 'hFFF8);

    check("busy_done_overlap", overlap_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
